// File: rtl/sgd_wb_pkg.sv
// Shared definitions for the SGD model write-back receiver.
//   BEAT_BYTES / BEAT_SHIFT : bytes per 512-bit beat and its log2
//   wb_state_t              : write-back FSM states
//   beats_from_bytes        : ceil(bytes/64), computed in 33-bit arithmetic
//   burst_len_m1            : beats-1 of the next burst, capped at max_beats
package sgd_wb_pkg;

  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned BEAT_SHIFT = 6;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned LEN_W      = 32;
  localparam int unsigned SUM_W      = LEN_W + 1;
  localparam int unsigned REM_W      = SUM_W - BEAT_SHIFT;
  localparam int unsigned CMD_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } wb_state_t;

  // Extra bit keeps length + 63 from wrapping for lengths near 4 GB.
  function automatic logic [REM_W-1:0] beats_from_bytes(input logic [LEN_W-1:0] bytes);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, bytes} + SUM_W'(BEAT_BYTES - 1);
    return REM_W'(sum >> BEAT_SHIFT);
  endfunction

  // Caller guarantees rem != 0.
  function automatic logic [CMD_LEN_W-1:0] burst_len_m1(input logic [REM_W-1:0] rem,
                                                        input int unsigned   max_beats);
    if (rem >= REM_W'(max_beats)) return CMD_LEN_W'(max_beats - 1);
    return CMD_LEN_W'(rem - REM_W'(1));
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// First-word-fall-through FIFO buffering model beats ahead of the write port.
//   clk, rst_n       : clock, synchronous active-low reset (flushes contents)
//   push, push_data  : write side; a push while full is dropped unless a pop
//                      happens in the same cycle
//   pop, head        : read side; head shows the oldest entry without a pop
//   empty            : no entries held
//   almost_full      : registered, occupancy >= DEPTH-AF_MARGIN last cycle
//   overflow         : sticky, set by a dropped push
module wb_sync_fifo #(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned AF_MARGIN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so push-while-full is legal then.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      almost_full <= (count >= CNT_W'(DEPTH - AF_MARGIN));
      if (push & full & ~do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/sgd_model_writeback.sv
// Receiver for the SGD engine model write-back: buffers x_data_in beats and
// turns each send-back request into 64 B-aligned write bursts of at most
// BURST_BEATS beats (command, then its data, never overlapping bursts).
//   x_data_send_back_*     : request (start pulse, byte address, byte length)
//   x_data_in*             : model beat stream with almost_full backpressure
//   wr_cmd_*               : burst command channel (valid/ready, addr, beats-1)
//   wr_data*               : burst data channel (valid/ready, beat, last)
//   wb_done                : one-cycle pulse when a request completes
//   wb_overflow            : sticky, beat dropped because the buffer was full
//   wb_busy                : FSM not idle
// Optional build macro SGD_WB_CHECKSUM_EN adds wb_checksum, the XOR of all
// 32-bit words of every beat popped in the current request.
module sgd_model_writeback
  import sgd_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned AF_MARGIN   = 8,
  parameter int unsigned BURST_BEATS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  x_data_send_back_start,
  input  logic [ADDR_W-1:0]     x_data_send_back_addr,
  input  logic [LEN_W-1:0]      x_data_send_back_length,
  input  logic [DATA_WIDTH-1:0] x_data_in,
  input  logic                  x_data_in_valid,
  output logic                  x_data_in_almost_full,
  output logic                  wr_cmd_valid,
  input  logic                  wr_cmd_ready,
  output logic [ADDR_W-1:0]     wr_cmd_addr,
  output logic [CMD_LEN_W-1:0]  wr_cmd_len,
  output logic                  wr_data_valid,
  input  logic                  wr_data_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_last,
  output logic                  wb_done,
  output logic                  wb_overflow,
  output logic                  wb_busy
`ifdef SGD_WB_CHECKSUM_EN
  ,
  output logic [31:0]           wb_checksum
`endif
);

  wb_state_t             state;
  logic [ADDR_W-1:0]     addr;
  logic [REM_W-1:0]      remaining;
  logic [CMD_LEN_W-1:0]  cmd_len;
  logic [CMD_LEN_W-1:0]  beat_cnt;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_empty;
  logic                  beat_pop;
  logic                  last_beat;
  logic [REM_W-1:0]      start_beats;
  logic [REM_W-1:0]      rem_after;
  logic [ADDR_W-1:0]     start_addr;

  wb_sync_fifo #(
    .WIDTH     (DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (x_data_in_valid),
    .push_data   (x_data_in),
    .pop         (beat_pop),
    .head        (fifo_head),
    .empty       (fifo_empty),
    .almost_full (x_data_in_almost_full),
    .overflow    (wb_overflow)
  );

  // Data channel is a decode of registered state and FIFO occupancy.
  assign wr_data_valid = (state == DATA) & ~fifo_empty;
  assign wr_data       = wr_data_valid ? fifo_head : '0;
  assign last_beat     = (beat_cnt == cmd_len);
  assign wr_data_last  = wr_data_valid & last_beat;
  assign beat_pop      = wr_data_valid & wr_data_ready;
  assign wb_busy       = (state != IDLE);

  assign wr_cmd_addr   = addr;
  assign wr_cmd_len    = cmd_len;

  assign start_beats   = beats_from_bytes(x_data_send_back_length);
  assign start_addr    = x_data_send_back_addr & ~ADDR_W'(BEAT_BYTES - 1);
  assign rem_after     = remaining - (REM_W'(cmd_len) + REM_W'(1));

  // Request FSM with address/remaining bookkeeping and burst splitting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      cmd_len      <= '0;
      beat_cnt     <= '0;
      wr_cmd_valid <= 1'b0;
      wb_done      <= 1'b0;
    end else begin
      // Pulse follows the single cycle spent in DONE.
      wb_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (x_data_send_back_start) begin
            addr      <= start_addr;
            remaining <= start_beats;
            if (start_beats == '0) begin
              state <= DONE;
            end else begin
              state        <= CMD;
              wr_cmd_valid <= 1'b1;
              cmd_len      <= burst_len_m1(start_beats, BURST_BEATS);
            end
          end
        end
        CMD: begin
          if (wr_cmd_ready) begin
            wr_cmd_valid <= 1'b0;
            beat_cnt     <= '0;
            state        <= DATA;
          end
        end
        DATA: begin
          if (beat_pop) begin
            if (last_beat) begin
              remaining <= rem_after;
              addr      <= addr + ((ADDR_W'(cmd_len) + ADDR_W'(1)) << BEAT_SHIFT);
              if (rem_after == '0) begin
                state <= DONE;
              end else begin
                state        <= CMD;
                wr_cmd_valid <= 1'b1;
                cmd_len      <= burst_len_m1(rem_after, BURST_BEATS);
              end
            end else begin
              beat_cnt <= beat_cnt + CMD_LEN_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SGD_WB_CHECKSUM_EN
  localparam int unsigned WORDS = DATA_WIDTH / 32;

  function automatic logic [31:0] fold_beat(input logic [DATA_WIDTH-1:0] beat);
    logic [31:0] acc;
    acc = '0;
    for (int w = 0; w < int'(WORDS); w++) acc = acc ^ beat[w*32 +: 32];
    return acc;
  endfunction

  // Running XOR over the request's popped beats; holds after completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_checksum <= '0;
    end else if ((state == IDLE) && x_data_send_back_start) begin
      wb_checksum <= '0;
    end else if (beat_pop) begin
      wb_checksum <= wb_checksum ^ fold_beat(fifo_head);
    end
  end
`endif

endmodule
